fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles strobe held awaiting fpu_done before abort.
REQ-002 Port clk  in  1  the single clock; all state on rising edge.
REQ-003 Port rst  in  1  asynchronous, active-high reset.
REQ-004 Port start  in  1  instruction valid from fetch; sampled only in IDLE.
REQ-005 Port instr  in  16  [15:12] opcode, [11:8] dest, [7:4] srcA, [3:0] srcB.
REQ-006 Port busy  out  1  high in every non-IDLE state.
REQ-007 Port done  out  1  one-cycle completion pulse.
REQ-008 Port err  out  1  high with done when the instruction aborted; held until next accepted start.
REQ-009 Port vadd, vdot, smul  out  1 each  one-hot FPU operation strobes.
REQ-010 Port ra, rb  out  4 each  register-file read addresses = latched srcA/srcB.
REQ-011 Port fpu_done  in  1  FPU result valid.
REQ-012 Port fpu_v  in  1  FPU vector-add overflow flag.
REQ-013 Port vout  in  256  FPU vector result; sout  in  16  FPU scalar result.
REQ-014 Port vrf_we  out  1; vrf_waddr  out  4; vrf_wdata  out  256  vector register write port.
REQ-015 Port srf_we  out  1; srf_waddr  out  4; srf_wdata  out  16  scalar register write port.

Function
REQ-016 States IDLE, ISSUE, WB, ABORT; encoding from shared package.
REQ-017 IDLE: start=1 latches instr, clears err; opcode 4'h1 VADD, 4'h2 VDOT, 4'h3 SMUL -> ISSUE; any other opcode -> ABORT.
REQ-018 ISSUE: exactly one strobe high per latched opcode, held every cycle in ISSUE; timeout counter increments each ISSUE cycle.
REQ-019 ISSUE, fpu_done=1 sampled: capture vout, sout, fpu_v into result registers; -> WB; strobe low from WB onward.
REQ-020 ISSUE, fpu_done=0 and counter = TIMEOUT-1: -> ABORT; counter width clog2(TIMEOUT+1), no wrap.
REQ-021 WB (one cycle): VADD -> vrf_we=1, vrf_waddr=dest, vrf_wdata=captured vout; VDOT same.
REQ-022 WB, SMUL: srf_we=1, srf_waddr=dest, srf_wdata=captured sout; vrf_we=0.
REQ-023 WB, VADD with captured fpu_v=1: additionally srf_we=1, srf_waddr=4'hF, srf_wdata=latched instr (exception record).
REQ-024 WB: done=1, err=0; -> IDLE.
REQ-025 ABORT (one cycle): done=1, err=1, no write enables, no strobes; -> IDLE.
REQ-026 Latency: start at cycle 0, strobe from cycle 1; fpu_done sampled at cycle k gives write+done at cycle k+1; minimum 2 cycles start-to-done.
REQ-027 start while busy ignored, not queued; start and done in same cycle impossible (done only outside IDLE).
REQ-028 fpu_done while not in ISSUE ignored.
REQ-029 Write enables, done, strobes are never high outside the stated states.

Reset
REQ-030 rst=1 asynchronously forces IDLE; busy, done, err, vadd, vdot, smul, vrf_we, srf_we = 0; addresses, data, latched instr, counter, result registers = 0.
REQ-031 Reset mid-ISSUE or mid-WB aborts with no write and no done pulse; first start after rst release accepted normally.

Structure
REQ-032 Shared package fpu_pkg holds opcode constants, instr field positions, state enum, exception register address 4'hF, vector/scalar widths 256/16.
REQ-033 No sub-module; FSM, timeout counter and result registers live in fpu_issue_ctrl.

Verification
REQ-034 VADD instr 16'h1312, fpu_done at 3rd strobe cycle, vout=all 16'h3C00 -> vrf_we one cycle, vrf_waddr=3, data=all 16'h3C00, done=1, err=0, cycle 4.
REQ-035 VADD 16'h1512 with fpu_v=1 -> vrf write to 5 and srf write addr 15 data 16'h1512 in same cycle.
REQ-036 SMUL 16'h3A01, fpu_done immediate, sout=16'h4200 -> smul high one cycle, srf write addr 10 data 16'h4200 at cycle 2.
REQ-037 VDOT 16'h2012, fpu_done never -> vdot held 15 cycles, then done=1, err=1, no writes; opcode 16'h7000 -> ABORT next cycle.
REQ-038 rst asserted during ISSUE of VADD -> all outputs 0 same cycle, no write; start during busy ignored.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, instruction
// field positions, FSM state encoding and datapath widths.
package fpu_pkg;

    localparam int IW = 16;
    localparam int VW = 256;
    localparam int SW = 16;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DEST_HI = 11;
    localparam int DEST_LO = 8;
    localparam int SRCA_HI = 7;
    localparam int SRCA_LO = 4;
    localparam int SRCB_HI = 3;
    localparam int SRCB_LO = 0;

    localparam logic [3:0] OP_VADD  = 4'h1;
    localparam logic [3:0] OP_VDOT  = 4'h2;
    localparam logic [3:0] OP_SMUL  = 4'h3;
    localparam logic [3:0] EXC_ADDR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OP_VADD) || (op == OP_VDOT) || (op == OP_SMUL);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// FPU-side bus of the issue controller: operation strobes, operand read
// addresses, FPU results, and the vector/scalar register write ports.
interface fpu_issue_ctrl_if;
    import fpu_pkg::*;

    logic          vadd;
    logic          vdot;
    logic          smul;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic          fpu_done;
    logic          fpu_v;
    logic [VW-1:0] vout;
    logic [SW-1:0] sout;
    logic          vrf_we;
    logic [3:0]    vrf_waddr;
    logic [VW-1:0] vrf_wdata;
    logic          srf_we;
    logic [3:0]    srf_waddr;
    logic [SW-1:0] srf_wdata;

    modport master (
        output vadd, vdot, smul, ra, rb,
        input  fpu_done, fpu_v, vout, sout,
        output vrf_we, vrf_waddr, vrf_wdata,
        output srf_we, srf_waddr, srf_wdata
    );

    modport slave (
        input  vadd, vdot, smul, ra, rb,
        output fpu_done, fpu_v, vout, sout,
        input  vrf_we, vrf_waddr, vrf_wdata,
        input  srf_we, srf_waddr, srf_wdata
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-instruction FPU issue controller: latches an instruction, strobes
// the FPU until it answers or times out, then writes the result back.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IW-1:0]     instr,
    output logic              busy,
    output logic              done,
    output logic              err,
    fpu_issue_ctrl_if.master  fpu
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VW-1:0]   vres_q, vres_d;
    logic [SW-1:0]   sres_q, sres_d;
    logic            vflag_q, vflag_d;
    logic            err_q, err_d;
    logic [3:0]      opc;
    logic [3:0]      dest;

    assign opc  = instr_q[OPC_HI:OPC_LO];
    assign dest = instr_q[DEST_HI:DEST_LO];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
            vres_q  <= '0;
            sres_q  <= '0;
            vflag_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            vres_q  <= vres_d;
            sres_q  <= sres_d;
            vflag_q <= vflag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        vres_d  = vres_q;
        sres_d  = sres_q;
        vflag_d = vflag_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    cnt_d   = '0;
                    // err is registered, so an unknown opcode raises it on the way into ABORT
                    err_d   = !is_valid_op(instr[OPC_HI:OPC_LO]);
                    state_d = is_valid_op(instr[OPC_HI:OPC_LO]) ? ST_ISSUE : ST_ABORT;
                end
            end
            ST_ISSUE: begin
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                if (fpu.fpu_done) begin
                    vres_d  = fpu.vout;
                    sres_d  = fpu.sout;
                    vflag_d = fpu.fpu_v;
                    state_d = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        err           = err_q;
        fpu.ra        = instr_q[SRCA_HI:SRCA_LO];
        fpu.rb        = instr_q[SRCB_HI:SRCB_LO];
        fpu.vadd      = 1'b0;
        fpu.vdot      = 1'b0;
        fpu.smul      = 1'b0;
        fpu.vrf_we    = 1'b0;
        fpu.vrf_waddr = '0;
        fpu.vrf_wdata = '0;
        fpu.srf_we    = 1'b0;
        fpu.srf_waddr = '0;
        fpu.srf_wdata = '0;
        case (state_q)
            ST_ISSUE: begin
                fpu.vadd = (opc == OP_VADD);
                fpu.vdot = (opc == OP_VDOT);
                fpu.smul = (opc == OP_SMUL);
            end
            ST_WB: begin
                done = 1'b1;
                if (opc == OP_VADD || opc == OP_VDOT) begin
                    fpu.vrf_we    = 1'b1;
                    fpu.vrf_waddr = dest;
                    fpu.vrf_wdata = vres_q;
                end
                if (opc == OP_SMUL) begin
                    fpu.srf_we    = 1'b1;
                    fpu.srf_waddr = dest;
                    fpu.srf_wdata = sres_q;
                end else if (opc == OP_VADD && vflag_q) begin
                    // overflow leaves the offending instruction in the exception register
                    fpu.srf_we    = 1'b1;
                    fpu.srf_waddr = EXC_ADDR;
                    fpu.srf_wdata = instr_q;
                end
            end
            ST_ABORT: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: hand-computed vectors for each opcode,
// overflow record, timeout, illegal opcode and reset during issue.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   instr;
    logic          busy;
    logic          done;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .instr (instr),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .fpu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_we"}, 256'({bus.vrf_we, bus.srf_we}), 256'(0));
        chk({tag, "_strb"}, 256'({bus.vadd, bus.vdot, bus.smul}), 256'(0));
    endtask

    logic [255:0] v_ones;
    logic [255:0] v_pat;

    initial begin
        v_ones = {16{16'h3C00}};
        v_pat  = {8{32'hDEADBEEF}};
        rst = 1'b1; start = 1'b0; instr = '0;
        bus.fpu_done = 1'b0; bus.fpu_v = 1'b0; bus.vout = '0; bus.sout = '0;
        tick(); tick();
        chk_idle("rst");
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_addr", 256'({bus.ra, bus.rb, bus.vrf_waddr, bus.srf_waddr}), 256'(0));
        chk("rst_data", bus.vrf_wdata, 256'(0));
        rst = 1'b0;
        tick();
        $display("txn reset: busy=%0b done=%0b err=%0b", busy, done, err);

        // VADD 1312, fpu_done on the 3rd strobe cycle, restart attempt while busy
        start = 1'b1; instr = 16'h1312;
        tick(); start = 1'b1; instr = 16'h3F00;
        chk("vadd_c1_strb", 256'({bus.vadd, bus.vdot, bus.smul}), 256'(3'b100));
        chk("vadd_c1_busy", 256'(busy), 256'(1));
        chk("vadd_c1_rarb", 256'({bus.ra, bus.rb}), 256'(8'h12));
        tick(); start = 1'b0;
        chk("vadd_c2_strb", 256'(bus.vadd), 256'(1));
        tick();
        chk("vadd_c3_strb", 256'(bus.vadd), 256'(1));
        chk("vadd_c3_done", 256'(done), 256'(0));
        bus.fpu_done = 1'b1; bus.vout = v_ones;
        tick(); bus.fpu_done = 1'b0; bus.vout = '0;
        chk("vadd_c4_vwe", 256'(bus.vrf_we), 256'(1));
        chk("vadd_c4_vaddr", 256'(bus.vrf_waddr), 256'(3));
        chk("vadd_c4_vdata", bus.vrf_wdata, v_ones);
        chk("vadd_c4_doneerr", 256'({done, err}), 256'(2'b10));
        chk("vadd_c4_swe", 256'(bus.srf_we), 256'(0));
        chk("vadd_c4_strb", 256'(bus.vadd), 256'(0));
        $display("txn vadd 1312: vrf_we=%0b waddr=%0d done=%0b err=%0b", bus.vrf_we, bus.vrf_waddr, done, err);
        tick();
        chk_idle("vadd_c5");

        // VADD 1512 with overflow: vector write plus exception record
        start = 1'b1; instr = 16'h1512;
        tick(); start = 1'b0;
        bus.fpu_done = 1'b1; bus.fpu_v = 1'b1; bus.vout = v_pat;
        tick(); bus.fpu_done = 1'b0; bus.fpu_v = 1'b0; bus.vout = '0;
        chk("ovf_vwe_addr", 256'({bus.vrf_we, bus.vrf_waddr}), 256'(5'h15));
        chk("ovf_vdata", bus.vrf_wdata, v_pat);
        chk("ovf_swe_addr", 256'({bus.srf_we, bus.srf_waddr}), 256'(5'h1F));
        chk("ovf_sdata", 256'(bus.srf_wdata), 256'(16'h1512));
        chk("ovf_done", 256'(done), 256'(1));
        $display("txn vadd 1512 ovf: srf_we=%0b saddr=%0d sdata=%h", bus.srf_we, bus.srf_waddr, bus.srf_wdata);
        tick();

        // VDOT 2012 with no answer: 15 strobe cycles then abort
        start = 1'b1; instr = 16'h2012;
        tick(); start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("vdot_hold%0d", i), 256'({bus.vdot, done}), 256'(2'b10));
            tick();
        end
        chk("vdot_abort_doneerr", 256'({done, err}), 256'(2'b11));
        chk("vdot_abort_we", 256'({bus.vrf_we, bus.srf_we}), 256'(0));
        chk("vdot_abort_strb", 256'(bus.vdot), 256'(0));
        $display("txn vdot 2012 timeout: done=%0b err=%0b", done, err);
        bus.fpu_done = 1'b1;
        tick();
        chk_idle("vdot_after");
        chk("vdot_err_held", 256'(err), 256'(1));
        tick(); bus.fpu_done = 1'b0;
        chk_idle("stray_fpu_done");

        // SMUL 3A01, immediate answer; fpu_v must not redirect the write
        start = 1'b1; instr = 16'h3A01;
        tick(); start = 1'b0;
        chk("smul_c1_strb", 256'({bus.vadd, bus.vdot, bus.smul}), 256'(3'b001));
        chk("smul_c1_err", 256'(err), 256'(0));
        bus.fpu_done = 1'b1; bus.fpu_v = 1'b1; bus.sout = 16'h4200;
        tick(); bus.fpu_done = 1'b0; bus.fpu_v = 1'b0; bus.sout = '0;
        chk("smul_c2_swe_addr", 256'({bus.srf_we, bus.srf_waddr}), 256'(5'h1A));
        chk("smul_c2_sdata", 256'(bus.srf_wdata), 256'(16'h4200));
        chk("smul_c2_vwe", 256'(bus.vrf_we), 256'(0));
        chk("smul_c2_doneerr", 256'({done, err, bus.smul}), 256'(3'b100));
        $display("txn smul 3a01: srf_we=%0b saddr=%0d sdata=%h", bus.srf_we, bus.srf_waddr, bus.srf_wdata);
        tick();

        // illegal opcode aborts on the next cycle
        start = 1'b1; instr = 16'h7000;
        tick(); start = 1'b0;
        chk("ill_doneerrbusy", 256'({done, err, busy}), 256'(3'b111));
        chk("ill_strb_we", 256'({bus.vadd, bus.vdot, bus.smul, bus.vrf_we, bus.srf_we}), 256'(0));
        $display("txn illegal 7000: done=%0b err=%0b", done, err);
        tick();
        chk_idle("ill_after");

        // reset in the middle of a VADD issue
        start = 1'b1; instr = 16'h1312;
        tick(); start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out", 256'({busy, done, err, bus.vadd, bus.vrf_we, bus.srf_we}), 256'(0));
        chk("rst_mid_rarb", 256'({bus.ra, bus.rb}), 256'(0));
        bus.fpu_done = 1'b1; bus.vout = v_ones;
        tick();
        chk_idle("rst_mid_hold");
        rst = 1'b0;
        tick(); bus.fpu_done = 1'b0; bus.vout = '0;
        chk_idle("rst_release");
        start = 1'b1; instr = 16'h3A01;
        tick(); start = 1'b0;
        chk("post_rst_smul", 256'({bus.smul, busy}), 256'(2'b11));
        $display("txn reset mid-issue: smul after release=%0b", bus.smul);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
